ddr_load_sched: RTL and testbench

- Schedules the single DDR read stream among the three loaders of the CNN memory subsystem: feature-in register matrix, weight register matrix and bias register array.
- Arbitrates loader requests and issues one DDR read burst per grant.
- Counts returned beats and steers them with per-destination valid, select and last strobes aligned to the data bus.
- Manages the weight ping-pong banks (write/read select plus full flags).
- The data bus is not carried through this block; only control is.

---
 rtl/ddr_load_sched_if.sv | 35 +++
 rtl/ddr_load_sched.sv | 186 ++++++++++++++++++
 tb/tb_ddr_load_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_load_sched_if.sv
// DDR read-command and read-return control bundle between the load scheduler
// and the DDR read port. The data bus is not carried here; only control is.
//   ddr_rd_req_o : read command valid (scheduler -> DDR)
//   ddr_rd_len_o : read command length, beats-1 (scheduler -> DDR)
//   ddr_rd_ack_i : command accepted (DDR -> scheduler)
//   ddr_valid_i  : read data beat valid (DDR -> scheduler)
//   ddr_last_i   : last beat of burst (DDR -> scheduler)
// Signal suffixes are written from the scheduler's point of view.
interface ddr_load_sched_if #(
    parameter int unsigned LW = 8
);
    logic          ddr_rd_req_o;
    logic [LW-1:0] ddr_rd_len_o;
    logic          ddr_rd_ack_i;
    logic          ddr_valid_i;
    logic          ddr_last_i;

    // Scheduler side
    modport master (
        output ddr_rd_req_o,
        output ddr_rd_len_o,
        input  ddr_rd_ack_i,
        input  ddr_valid_i,
        input  ddr_last_i
    );

    // DDR read port side
    modport slave (
        input  ddr_rd_req_o,
        input  ddr_rd_len_o,
        output ddr_rd_ack_i,
        output ddr_valid_i,
        output ddr_last_i
    );
endinterface

// File: rtl/ddr_load_sched.sv
// Shares the single DDR read stream among the feature, weight and bias loaders.
// Fixed-priority arbitration (bias > weight > feature), one DDR burst per grant,
// beat counting with zero-latency per-destination strobes, and weight ping-pong
// bank bookkeeping.
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   feat/wgt/bias _req_i, _len_i   loader burst requests (level) and beats-1
//   feat/wgt/bias _done_o          one-cycle burst-complete pulses
//   ddr                            DDR command/return control (master modport)
//   sel_ddr_o, ddr_last_o          feature-matrix beat strobe and final beat
//   weight_valid_o                 weight-matrix beat strobe
//   sel_weight_w_o/_r_o            weight bank being written / read
//   wgt_ready_o, wgt_consume_i     read bank full / datapath done with it
//   bias_valid_o, last_bias_o      bias-array beat strobe and final beat
//   busy_o, err_o                  FSM not idle, sticky length/last mismatch
module ddr_load_sched #(
    parameter int unsigned LW = 8,
    parameter int unsigned NB = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    ddr_load_sched_if.master        ddr,
    input  logic                    feat_req_i,
    input  logic [LW-1:0]           feat_len_i,
    output logic                    feat_done_o,
    input  logic                    wgt_req_i,
    input  logic [LW-1:0]           wgt_len_i,
    output logic                    wgt_done_o,
    input  logic                    bias_req_i,
    input  logic [LW-1:0]           bias_len_i,
    output logic                    bias_done_o,
    output logic                    sel_ddr_o,
    output logic                    ddr_last_o,
    output logic                    weight_valid_o,
    output logic                    sel_weight_w_o,
    output logic                    sel_weight_r_o,
    output logic                    wgt_ready_o,
    input  logic                    wgt_consume_i,
    output logic                    bias_valid_o,
    output logic                    last_bias_o,
    output logic                    busy_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_FEAT,
        OWN_WGT,
        OWN_BIAS
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [LW-1:0] len_q,   len_d;
    logic [LW-1:0] cnt_q,   cnt_d;
    logic [NB-1:0] bank_full_q, bank_full_d;
    logic          wptr_q,  wptr_d;
    logic          rptr_q,  rptr_d;
    logic          err_q,   err_d;

    logic          stream_c;
    logic          at_len_c;
    logic          final_beat_c;

    assign stream_c     = (state_q == S_STREAM);
    assign at_len_c     = (cnt_q == len_q);
    assign final_beat_c = stream_c & ddr.ddr_valid_i & at_len_c;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_FEAT;
            len_q       <= '0;
            cnt_q       <= '0;
            bank_full_q <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            bank_full_q <= bank_full_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            err_q       <= err_d;
        end
    end

    // Next-state: arbitration, burst sequencing, bank bookkeeping, error capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        bank_full_d = bank_full_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                // Weight is skipped while its write bank is still full.
                if (bias_req_i) begin
                    owner_d = OWN_BIAS;
                    len_d   = bias_len_i;
                    state_d = S_ISSUE;
                end else if (wgt_req_i && !bank_full_q[wptr_q]) begin
                    owner_d = OWN_WGT;
                    len_d   = wgt_len_i;
                    state_d = S_ISSUE;
                end else if (feat_req_i) begin
                    owner_d = OWN_FEAT;
                    len_d   = feat_len_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ddr.ddr_rd_ack_i) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // Termination follows the local count; ddr_last only flags errors.
                if (ddr.ddr_valid_i) begin
                    cnt_d = cnt_q + LW'(1);
                    if (ddr.ddr_last_i != at_len_c) begin
                        err_d = 1'b1;
                    end
                    if (at_len_c) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (owner_q == OWN_WGT) begin
                    bank_full_d[wptr_q] = 1'b1;
                    wptr_d              = ~wptr_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Beats with no open burst have nowhere to go.
        if (ddr.ddr_valid_i && !stream_c) begin
            err_d = 1'b1;
        end

        // Consume targets the read bank, never the bank being filled in DONE.
        if (wgt_consume_i && bank_full_q[rptr_q]) begin
            bank_full_d[rptr_q] = 1'b0;
            rptr_d              = ~rptr_q;
        end
    end

    assign ddr.ddr_rd_req_o = (state_q == S_ISSUE);
    assign ddr.ddr_rd_len_o = (state_q == S_ISSUE) ? len_q : '0;

    // Strobes are combinational so they line up with the data beat.
    assign sel_ddr_o      = stream_c & ddr.ddr_valid_i & (owner_q == OWN_FEAT);
    assign weight_valid_o = stream_c & ddr.ddr_valid_i & (owner_q == OWN_WGT);
    assign bias_valid_o   = stream_c & ddr.ddr_valid_i & (owner_q == OWN_BIAS);
    assign ddr_last_o     = sel_ddr_o & final_beat_c;
    assign last_bias_o    = bias_valid_o & final_beat_c;

    assign feat_done_o = (state_q == S_DONE) & (owner_q == OWN_FEAT);
    assign wgt_done_o  = (state_q == S_DONE) & (owner_q == OWN_WGT);
    assign bias_done_o = (state_q == S_DONE) & (owner_q == OWN_BIAS);

    assign sel_weight_w_o = wptr_q;
    assign sel_weight_r_o = rptr_q;
    assign wgt_ready_o    = bank_full_q[rptr_q];
    assign busy_o         = (state_q != S_IDLE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_ddr_load_sched.sv
// Directed bench for ddr_load_sched: a small DDR responder task drives the
// command/return side and tallies the strobes of each burst for comparison
// against hand-computed values.
module tb_ddr_load_sched;

    localparam int unsigned LW = 8;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          feat_req_i, wgt_req_i, bias_req_i;
    logic [LW-1:0] feat_len_i, wgt_len_i, bias_len_i;
    logic          feat_done_o, wgt_done_o, bias_done_o;
    logic          sel_ddr_o, ddr_last_o, weight_valid_o;
    logic          sel_weight_w_o, sel_weight_r_o, wgt_ready_o, wgt_consume_i;
    logic          bias_valid_o, last_bias_o, busy_o, err_o;

    ddr_load_sched_if #(.LW(LW)) ifc ();

    ddr_load_sched #(.LW(LW), .NB(2)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .ddr            (ifc),
        .feat_req_i     (feat_req_i),
        .feat_len_i     (feat_len_i),
        .feat_done_o    (feat_done_o),
        .wgt_req_i      (wgt_req_i),
        .wgt_len_i      (wgt_len_i),
        .wgt_done_o     (wgt_done_o),
        .bias_req_i     (bias_req_i),
        .bias_len_i     (bias_len_i),
        .bias_done_o    (bias_done_o),
        .sel_ddr_o      (sel_ddr_o),
        .ddr_last_o     (ddr_last_o),
        .weight_valid_o (weight_valid_o),
        .sel_weight_w_o (sel_weight_w_o),
        .sel_weight_r_o (sel_weight_r_o),
        .wgt_ready_o    (wgt_ready_o),
        .wgt_consume_i  (wgt_consume_i),
        .bias_valid_o   (bias_valid_o),
        .last_bias_o    (last_bias_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-burst tallies filled by serve()
    int         s_sel, s_dlast, s_wv, s_wbank, s_bv, s_blast;
    logic [2:0] s_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [2:0] dones();
        return {bias_done_o, wgt_done_o, feat_done_o};
    endfunction

    // Waits for a read command, acks after ack_dly cycles, returns nbeats beats
    // with gap idle cycles before each, ddr_last on beat last_at. Returns in DONE.
    task automatic serve(input string tag, input int exp_len, input int ack_dly,
                         input int nbeats, input int gap, input int last_at);
        int waited = 0;
        s_sel = 0; s_dlast = 0; s_wv = 0; s_wbank = 0; s_bv = 0; s_blast = 0;
        s_done = 3'b000;
        while (!ifc.ddr_rd_req_o && waited < 20) begin
            step();
            waited++;
        end
        if (!ifc.ddr_rd_req_o) begin
            chk({tag, "_req_timeout"}, 32'(ifc.ddr_rd_req_o), 32'd1);
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            chk({tag, "_len_hold"}, 32'(ifc.ddr_rd_len_o), 32'(exp_len));
            step();
            chk({tag, "_req_hold"}, 32'(ifc.ddr_rd_req_o), 32'd1);
        end
        chk({tag, "_len"}, 32'(ifc.ddr_rd_len_o), 32'(exp_len));
        ifc.ddr_rd_ack_i = 1'b1;
        step();
        ifc.ddr_rd_ack_i = 1'b0;
        for (int b = 1; b <= nbeats; b++) begin
            repeat (gap) step();
            ifc.ddr_valid_i = 1'b1;
            ifc.ddr_last_i  = (b == last_at);
            #1;
            s_sel   += int'(sel_ddr_o);
            s_dlast += int'(ddr_last_o);
            s_wv    += int'(weight_valid_o);
            s_wbank += int'(weight_valid_o & sel_weight_w_o);
            s_bv    += int'(bias_valid_o);
            s_blast += int'(last_bias_o);
            step();
            ifc.ddr_valid_i = 1'b0;
            ifc.ddr_last_i  = 1'b0;
        end
        s_done = dones();
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #3;
        rstn_i = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rstn_i = 1'b0;
        feat_req_i = 1'b0; wgt_req_i = 1'b0; bias_req_i = 1'b0;
        feat_len_i = '0;   wgt_len_i = '0;   bias_len_i = '0;
        wgt_consume_i = 1'b0;
        ifc.ddr_rd_ack_i = 1'b0; ifc.ddr_valid_i = 1'b0; ifc.ddr_last_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_req",   32'(ifc.ddr_rd_req_o), 32'd0);
        chk("rst_len",   32'(ifc.ddr_rd_len_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_ready", 32'(wgt_ready_o), 32'd0);
        chk("rst_wsel",  32'(sel_weight_w_o), 32'd0);
        chk("rst_rsel",  32'(sel_weight_r_o), 32'd0);
        chk("rst_done",  32'(dones()), 32'd0);
        rstn_i = 1'b1;
        step();

        // Single feature burst, len 3, ack after 2 cycles
        feat_req_i = 1'b1; feat_len_i = 8'd3;
        serve("t1", 3, 2, 4, 0, 4);
        chk("t1_sel",   32'(s_sel), 32'd4);
        chk("t1_dlast", 32'(s_dlast), 32'd1);
        chk("t1_other", 32'(s_wv + s_bv), 32'd0);
        chk("t1_done",  32'(s_done), 32'b001);
        chk("t1_err",   32'(err_o), 32'd0);
        feat_req_i = 1'b0;
        step();
        chk("t1_done_clr", 32'(dones()), 32'd0);
        chk("t1_idle",     32'(busy_o), 32'd0);

        // Simultaneous requests: bias, then weight, then feature
        bias_len_i = 8'd1; wgt_len_i = 8'd1; feat_len_i = 8'd1;
        bias_req_i = 1'b1; wgt_req_i = 1'b1; feat_req_i = 1'b1;
        serve("t2b", 1, 0, 2, 0, 2);
        chk("t2b_bv",    32'(s_bv), 32'd2);
        chk("t2b_blast", 32'(s_blast), 32'd1);
        chk("t2b_sel",   32'(s_sel + s_wv), 32'd0);
        chk("t2b_done",  32'(s_done), 32'b100);
        bias_req_i = 1'b0;
        serve("t2w", 1, 1, 2, 0, 2);
        chk("t2w_wv",    32'(s_wv), 32'd2);
        chk("t2w_wbank", 32'(s_wbank), 32'd0);
        chk("t2w_done",  32'(s_done), 32'b010);
        wgt_req_i = 1'b0;
        serve("t2f", 1, 0, 2, 0, 2);
        chk("t2f_sel",   32'(s_sel), 32'd2);
        chk("t2f_dlast", 32'(s_dlast), 32'd1);
        chk("t2f_done",  32'(s_done), 32'b001);
        feat_req_i = 1'b0;
        step();
        chk("t2_wsel",  32'(sel_weight_w_o), 32'd1);
        chk("t2_ready", 32'(wgt_ready_o), 32'd1);
        chk("t2_err",   32'(err_o), 32'd0);

        // Ping-pong: two fills, third stalls while a feature burst is served
        do_reset();
        chk("t3_rst_ready", 32'(wgt_ready_o), 32'd0);
        wgt_consume_i = 1'b1;
        step();
        wgt_consume_i = 1'b0;
        chk("t3_consume_ignored", 32'(sel_weight_r_o), 32'd0);
        wgt_len_i = 8'd2; wgt_req_i = 1'b1;
        serve("t3a", 2, 0, 3, 0, 3);
        chk("t3a_done",  32'(s_done), 32'b010);
        chk("t3a_wbank", 32'(s_wbank), 32'd0);
        serve("t3b", 2, 0, 3, 0, 3);
        chk("t3b_done",  32'(s_done), 32'b010);
        chk("t3b_wbank", 32'(s_wbank), 32'd3);
        step();
        feat_req_i = 1'b1; feat_len_i = 8'd0;
        serve("t3f", 0, 0, 1, 0, 1);
        chk("t3f_sel",   32'(s_sel), 32'd1);
        chk("t3f_dlast", 32'(s_dlast), 32'd1);
        chk("t3f_done",  32'(s_done), 32'b001);
        feat_req_i = 1'b0;
        repeat (3) step();
        chk("t3_stall_busy", 32'(busy_o), 32'd0);
        chk("t3_ready",      32'(wgt_ready_o), 32'd1);
        chk("t3_wsel",       32'(sel_weight_w_o), 32'd0);
        chk("t3_rsel",       32'(sel_weight_r_o), 32'd0);
        wgt_consume_i = 1'b1;
        step();
        wgt_consume_i = 1'b0;
        chk("t3_rsel_after", 32'(sel_weight_r_o), 32'd1);
        chk("t3_ready_b1",   32'(wgt_ready_o), 32'd1);
        serve("t3c", 2, 0, 3, 0, 3);
        chk("t3c_done",  32'(s_done), 32'b010);
        chk("t3c_wbank", 32'(s_wbank), 32'd0);
        wgt_req_i = 1'b0;
        step();
        chk("t3c_wsel", 32'(sel_weight_w_o), 32'd1);

        // Gapped beats in a len 7 burst
        feat_req_i = 1'b1; feat_len_i = 8'd7;
        serve("t4", 7, 0, 8, 1, 8);
        chk("t4_sel",   32'(s_sel), 32'd8);
        chk("t4_dlast", 32'(s_dlast), 32'd1);
        chk("t4_done",  32'(s_done), 32'b001);
        chk("t4_err",   32'(err_o), 32'd0);
        feat_req_i = 1'b0;
        step();

        // Early ddr_last: error flagged, burst still runs to count
        bias_req_i = 1'b1; bias_len_i = 8'd3;
        serve("t5", 3, 0, 4, 0, 2);
        chk("t5_bv",    32'(s_bv), 32'd4);
        chk("t5_blast", 32'(s_blast), 32'd1);
        chk("t5_done",  32'(s_done), 32'b100);
        chk("t5_err",   32'(err_o), 32'd1);
        bias_req_i = 1'b0;
        repeat (3) step();
        chk("t5_err_sticky", 32'(err_o), 32'd1);

        // Reset in the middle of a stream
        feat_req_i = 1'b1; feat_len_i = 8'd7;
        waited = 0;
        while (!ifc.ddr_rd_req_o && waited < 20) begin
            step();
            waited++;
        end
        chk("t6_req", 32'(ifc.ddr_rd_req_o), 32'd1);
        ifc.ddr_rd_ack_i = 1'b1;
        step();
        ifc.ddr_rd_ack_i = 1'b0;
        ifc.ddr_valid_i = 1'b1;
        step();
        step();
        chk("t6_mid_sel", 32'(sel_ddr_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_sel",   32'(sel_ddr_o), 32'd0);
        chk("t6_rst_busy",  32'(busy_o), 32'd0);
        chk("t6_rst_err",   32'(err_o), 32'd0);
        chk("t6_rst_ready", 32'(wgt_ready_o), 32'd0);
        chk("t6_rst_ptrs",  32'({sel_weight_w_o, sel_weight_r_o}), 32'd0);
        ifc.ddr_valid_i = 1'b0;
        feat_req_i = 1'b0;
        #2;
        rstn_i = 1'b1;
        step();
        chk("t6_idle", 32'(busy_o), 32'd0);
        feat_req_i = 1'b1; feat_len_i = 8'd1;
        serve("t6", 1, 0, 2, 0, 2);
        chk("t6_sel",  32'(s_sel), 32'd2);
        chk("t6_done", 32'(s_done), 32'b001);
        chk("t6_err",  32'(err_o), 32'd0);
        feat_req_i = 1'b0;
        step();

        // Stray beat while idle is dropped and flagged
        ifc.ddr_valid_i = 1'b1;
        #1;
        chk("t7_strobes", 32'({sel_ddr_o, weight_valid_o, bias_valid_o}), 32'd0);
        step();
        ifc.ddr_valid_i = 1'b0;
        chk("t7_err", 32'(err_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
